// File: rtl/read_data_ms.sv
// Read-data capture stage: registers read data/response on each valid&ready handshake.
// Latency: 1 cycle from the sampling edge to o_RDATA/o_RRESP.
// Backpressure: none generated; RREADY comes from the sink and is only observed here.
//
// Ports:
//   ACLK              clock, all state changes on rising edge
//   ARESETn           asynchronous reset, ACTIVE-HIGH (1 = reset) despite its name
//   RVALID / RREADY   read channel handshake
//   i_RDATA, i_RRESP  incoming read data / response
//   o_RDATA, o_RRESP  captured read data / response, held between handshakes
//
// Optional: define READ_DATA_MS_PROTOCOL_CHECK_EN to compile simulation-only
// checks that flag RVALID dropping, or payload changing, while stalled in WAIT.
module read_data_ms #(
  parameter int DATA_W = 32,
  parameter int RESP_W = 2
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic              RVALID,
  input  logic              RREADY,
  input  logic [DATA_W-1:0] i_RDATA,
  output logic [DATA_W-1:0] o_RDATA,
  input  logic [RESP_W-1:0] i_RRESP,
  output logic [RESP_W-1:0] o_RRESP
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   capture;

  // Every state reacts to the handshake the same way: a valid&ready edge
  // always captures and lands in DONE, so back-to-back beats cost one cycle each.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (RVALID && RREADY) begin
          state_nxt = DONE;
          capture   = 1'b1;
        end else if (RVALID) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (!RVALID) begin
          // Source withdrew its beat before the sink took it; drop it quietly.
          state_nxt = IDLE;
        end else if (RREADY) begin
          state_nxt = DONE;
          capture   = 1'b1;
        end
      end
      DONE: begin
        if (!RVALID) begin
          state_nxt = IDLE;
        end else if (RREADY) begin
          state_nxt = DONE;
          capture   = 1'b1;
        end else begin
          state_nxt = WAIT;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESETn) begin
    if (ARESETn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Reset has priority, so a beat coinciding with reset is discarded.
  always_ff @(posedge ACLK or posedge ARESETn) begin
    if (ARESETn) begin
      o_RDATA <= '0;
      o_RRESP <= '0;
    end else if (capture) begin
      o_RDATA <= i_RDATA;
      o_RRESP <= i_RRESP;
    end
  end

`ifdef READ_DATA_MS_PROTOCOL_CHECK_EN
  // Payload seen on the previous edge; while in WAIT the source must keep
  // RVALID high and the payload stable until the sink accepts it.
  logic [DATA_W-1:0] prev_rdata;
  logic [RESP_W-1:0] prev_rresp;

  always_ff @(posedge ACLK) begin
    prev_rdata <= i_RDATA;
    prev_rresp <= i_RRESP;
  end

  always @(posedge ACLK) begin
    if (!ARESETn && state == WAIT) begin
      if (!RVALID) begin
        $error("read_data_ms: RVALID dropped before handshake");
      end else if (i_RDATA !== prev_rdata || i_RRESP !== prev_rresp) begin
        $error("read_data_ms: read payload changed while waiting for RREADY");
      end
    end
  end
`endif

endmodule

// File: tb/tb_read_data_ms.sv
// Directed bench for read_data_ms: reset values, stall/hold, capture,
// back-to-back beats, withdrawn beats and asynchronous reset.
module tb_read_data_ms;

  logic        ACLK;
  logic        ARESETn;
  logic        RVALID;
  logic        RREADY;
  logic [31:0] i_RDATA;
  logic [31:0] o_RDATA;
  logic [1:0]  i_RRESP;
  logic [1:0]  o_RRESP;

  int n_checks;
  int n_fail;

  read_data_ms #(.DATA_W(32), .RESP_W(2)) dut (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .RVALID  (RVALID),
    .RREADY  (RREADY),
    .i_RDATA (i_RDATA),
    .o_RDATA (o_RDATA),
    .i_RRESP (i_RRESP),
    .o_RRESP (o_RRESP)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // Wait for the next rising edge, then settle 1 time unit past it.
  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [31:0] exp_data,
                           input logic [1:0] exp_resp);
    n_checks++;
    assert (o_RDATA === exp_data) else begin
      n_fail++;
      $error("FAIL %s data: got %h expected %h", tag, o_RDATA, exp_data);
    end
    n_checks++;
    assert (o_RRESP === exp_resp) else begin
      n_fail++;
      $error("FAIL %s resp: got %b expected %b", tag, o_RRESP, exp_resp);
    end
  endtask

  task automatic drive(input logic v, input logic r, input logic [31:0] d,
                       input logic [1:0] s);
    RVALID  = v;
    RREADY  = r;
    i_RDATA = d;
    i_RRESP = s;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    ARESETn  = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 2'b00);
    #1;
    check_out("reset_async", 32'h0, 2'b00);

    // Handshake presented while reset is held: reset wins.
    drive(1'b1, 1'b1, 32'hDEADBEEF, 2'b10);
    step();
    check_out("reset_beats_capture", 32'h0, 2'b00);
    step();
    check_out("reset_held", 32'h0, 2'b00);

    // Release between edges with no beat pending.
    drive(1'b0, 1'b0, 32'h0, 2'b00);
    ARESETn = 1'b0;
    step();
    check_out("post_release_idle", 32'h0, 2'b00);

    // Stall: valid without ready for three edges.
    drive(1'b1, 1'b0, 32'hFFFFFFFF, 2'b01);
    for (int i = 0; i < 3; i++) begin
      step();
      check_out($sformatf("stall_%0d", i), 32'h0, 2'b00);
    end

    // Sink becomes ready: capture on next edge.
    RREADY = 1'b1;
    step();
    check_out("wait_to_done", 32'hFFFFFFFF, 2'b01);

    // Ready without valid: nothing captured despite changed inputs.
    drive(1'b0, 1'b1, 32'h12345678, 2'b10);
    for (int i = 0; i < 4; i++) begin
      step();
      check_out($sformatf("ready_no_valid_%0d", i), 32'hFFFFFFFF, 2'b01);
    end

    // Back-to-back beats, one per edge.
    drive(1'b1, 1'b1, 32'hA5A5A5A5, 2'b00);
    step();
    check_out("b2b_first", 32'hA5A5A5A5, 2'b00);
    drive(1'b1, 1'b1, 32'h5A5A5A5A, 2'b11);
    step();
    check_out("b2b_second", 32'h5A5A5A5A, 2'b11);

    // DONE -> WAIT, then beat withdrawn (WAIT -> IDLE) without capture.
    drive(1'b1, 1'b0, 32'h11112222, 2'b10);
    step();
    check_out("done_to_wait_hold", 32'h5A5A5A5A, 2'b11);
    drive(1'b0, 1'b0, 32'h11112222, 2'b10);
    step();
    check_out("withdrawn_beat", 32'h5A5A5A5A, 2'b11);

    // Fresh beat from IDLE captures in one edge.
    drive(1'b1, 1'b1, 32'hCAFEF00D, 2'b10);
    step();
    check_out("idle_capture", 32'hCAFEF00D, 2'b10);
    drive(1'b0, 1'b0, 32'h0, 2'b00);

    // Asynchronous reset between edges after a capture.
    #2;
    ARESETn = 1'b1;
    #1;
    check_out("async_reset_mid_cycle", 32'h0, 2'b00);
    drive(1'b1, 1'b1, 32'h77778888, 2'b01);
    step();
    check_out("reset_blocks_beat", 32'h0, 2'b00);

    // First handshake after release captures.
    ARESETn = 1'b0;
    drive(1'b1, 1'b1, 32'h0BADBEEF, 2'b11);
    step();
    check_out("first_after_release", 32'h0BADBEEF, 2'b11);

    // Reset during a stalled beat discards it; next handshake captures.
    drive(1'b1, 1'b0, 32'h13579BDF, 2'b01);
    step();
    check_out("stall_before_reset", 32'h0BADBEEF, 2'b11);
    ARESETn = 1'b1;
    #1;
    check_out("reset_in_wait", 32'h0, 2'b00);
    ARESETn = 1'b0;
    drive(1'b0, 1'b0, 32'h13579BDF, 2'b01);
    step();
    check_out("wait_discarded", 32'h0, 2'b00);
    drive(1'b1, 1'b1, 32'h2468ACE0, 2'b00);
    step();
    check_out("capture_after_discard", 32'h2468ACE0, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
